// File: rtl/keypad_pkg.sv
// Shared keypad definitions: FSM states, geometry, and row priority helper.
package keypad_pkg;

  localparam int KEY_CODE_W = 4;
  localparam int NUM_COLS   = 4;
  localparam int NUM_ROWS   = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Lowest-index asserted row wins when several keys share a column.
  function automatic logic [1:0] lowest_row(input logic [NUM_ROWS-1:0] r);
    if (r[0])      return 2'd0;
    else if (r[1]) return 2'd1;
    else if (r[2]) return 2'd2;
    else           return 2'd3;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop gives it a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: one-hot column drive, row debounce, press/hold/release tracking.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_LIMIT = 25000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_ROWS-1:0]   row,
  output logic [NUM_COLS-1:0]   col,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held
);

  localparam int CNT_MAX = (DEBOUNCE_LIMIT > SETTLE_CYCLES) ? DEBOUNCE_LIMIT : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] DB_END     = CW'(DEBOUNCE_LIMIT - 1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [1:0]          col_idx;
  logic [1:0]          row_idx;
  logic [NUM_ROWS-1:0] row_pat;
  logic [NUM_ROWS-1:0] row_s;

  sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row),
    .q     (row_s)
  );

  // Scan/debounce FSM; col rotates so it stays one-hot by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      cnt       <= '0;
      col_idx   <= 2'd0;
      col       <= 4'b0001;
      row_idx   <= 2'd0;
      row_pat   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt != SETTLE_END) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (|row_s) begin
              state   <= DEBOUNCE;
              row_pat <= row_s;
              row_idx <= lowest_row(row_s);
            end else begin
              col_idx <= col_idx + 2'd1;
              col     <= {col[NUM_COLS-2:0], col[NUM_COLS-1]};
            end
          end
        end
        DEBOUNCE: begin
          // Any change in the row pattern restarts the scan on this column.
          if (row_s != row_pat) begin
            state <= SCAN;
            cnt   <= '0;
          end else if (cnt == DB_END) begin
            state     <= PRESSED;
            cnt       <= '0;
            key_code  <= {col_idx, row_idx};
            key_valid <= 1'b1;
            key_held  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          // Only the accepted row matters; other keys in the column are ignored.
          if (!row_s[row_idx]) begin
            state <= RELEASE;
            cnt   <= '0;
          end
        end
        RELEASE: begin
          if (row_s[row_idx]) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DB_END) begin
            state    <= SCAN;
            cnt      <= '0;
            key_held <= 1'b0;
            col_idx  <= col_idx + 2'd1;
            col      <= {col[NUM_COLS-2:0], col[NUM_COLS-1]};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a key-matrix model and key_valid scoreboard.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;

  // Key matrix: pressed rows only connect while their column is driven.
  logic       press_on = 1'b0;
  logic       glitch = 1'b0;
  logic [3:0] press_col = 4'b0001;
  logic [3:0] press_rows = 4'b0000;

  assign row = (press_on && !glitch && (col == press_col)) ? press_rows : 4'b0000;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.SETTLE_CYCLES(2), .DEBOUNCE_LIMIT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait until col newly switches to target (so the settle count starts fresh).
  task automatic wait_enter(input logic [3:0] t, input int lim, input string name);
    int k;
    k = 0;
    while (col === t && k < lim) begin
      @(negedge clk);
      k++;
    end
    while (col !== t && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(name, col, t);
  endtask

  task automatic wait_col(input logic [3:0] t, input int lim, input string name);
    int k;
    k = 0;
    while (col !== t && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(name, col, t);
  endtask

  // Monitor: every key_valid pulse must match the next expected press.
  always @(negedge clk) begin
    if (rst_n && key_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_key_valid: got key_code %0h with no press expected", key_code);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_key_code", key_code, mon_exp);
        check("sb_key_held_with_valid", key_held, 1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ec;
    cyc(2);
    check("rst_col", col, 4'b0001);
    check("rst_key_code", key_code, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_held", key_held, 0);

    // Idle scan: each column held SETTLE_CYCLES+1 cycles.
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      ec = 4'b0001 << ((k / 3) % 4);
      check("idle_col_seq", col, ec);
      @(negedge clk);
    end

    // Single key at col 2 / row 2.
    wait_enter(4'b0100, 20, "t026_reach_col");
    press_col = 4'b0100; press_rows = 4'b0100; press_on = 1'b1;
    exp_q.push_back(4'b1010);
    cyc(30);
    check("t026_held_pressed", key_held, 1);
    press_on = 1'b0;
    cyc(5);
    check("t026_held_in_release", key_held, 1);
    cyc(9);
    check("t026_held_cleared", key_held, 0);
    check("t026_code_holds", key_code, 4'b1010);
    check("t026_one_valid", exp_q.size(), 0);

    // Glitch during debounce aborts and rescans the same column.
    cyc(3);
    wait_enter(4'b0010, 20, "t027_reach_col");
    press_col = 4'b0010; press_rows = 4'b0010; press_on = 1'b1;
    cyc(4);
    glitch = 1'b1;
    cyc(3);
    glitch = 1'b0;
    press_on = 1'b0;
    cyc(1);
    check("t027_same_col", col, 4'b0010);
    wait_col(4'b0100, 4, "t027_resume_next_col");

    // Multiple rows: lowest wins.
    cyc(3);
    wait_enter(4'b0001, 20, "t028_reach_col");
    press_col = 4'b0001; press_rows = 4'b0110; press_on = 1'b1;
    exp_q.push_back(4'b0001);
    cyc(25);
    press_on = 1'b0;
    cyc(20);
    check("t028_code", key_code, 4'b0001);
    check("t028_held_cleared", key_held, 0);

    // Short dip while pressed returns to PRESSED without a new pulse.
    wait_enter(4'b1000, 20, "t029_reach_col");
    press_col = 4'b1000; press_rows = 4'b1000; press_on = 1'b1;
    exp_q.push_back(4'b1111);
    cyc(20);
    glitch = 1'b1;
    cyc(3);
    glitch = 1'b0;
    cyc(3);
    check("t029_held_after_dip", key_held, 1);
    cyc(10);
    check("t029_held_later", key_held, 1);
    check("t029_col_held", col, 4'b1000);
    press_on = 1'b0;
    cyc(20);
    check("t029_held_cleared", key_held, 0);
    check("t029_code", key_code, 4'b1111);

    // Reset mid-debounce.
    wait_enter(4'b0010, 40, "t030_reach_col");
    press_col = 4'b0010; press_rows = 4'b0001; press_on = 1'b1;
    cyc(5);
    rst_n = 1'b0;
    #1;
    check("t030_rst_col", col, 4'b0001);
    check("t030_rst_code", key_code, 0);
    check("t030_rst_valid", key_valid, 0);
    check("t030_rst_held", key_held, 0);
    press_on = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    check("t030_col_after", col, 4'b0001);
    cyc(20);

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
